// File: rtl/renode_pkg.sv
// Shared types and limits for the Renode APB3 request arbiter.
package renode_pkg;

    localparam int MaxRequesters = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb3_arb_state_e;

endpackage

// File: rtl/renode_rr_arbiter.sv
// Combinational round-robin picker: the first set request bit at or above
// ptr (wrapping) wins and is returned both one-hot and as an index.
module renode_rr_arbiter #(
    parameter int NumRequesters = 2,
    parameter int IdxWidth      = 1
) (
    input  logic [NumRequesters-1:0] req,
    input  logic [IdxWidth-1:0]      ptr,
    output logic [NumRequesters-1:0] grant,
    output logic [IdxWidth-1:0]      idx,
    output logic                     req_any
);

    logic [IdxWidth:0] cand;
    logic              found;

    // Scan upward from the pointer with wrap; the first pending requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            cand = {1'b0, ptr} + (IdxWidth+1)'(i);
            if (cand >= (IdxWidth+1)'(NumRequesters)) begin
                cand = cand - (IdxWidth+1)'(NumRequesters);
            end
            if (!found && req[cand[IdxWidth-1:0]]) begin
                found                       = 1'b1;
                idx                         = cand[IdxWidth-1:0];
                grant[cand[IdxWidth-1:0]]   = 1'b1;
            end
        end
    end

    assign req_any = |req;

endmodule

// File: rtl/renode_apb3_arbiter.sv
// Shares one APB3 completer port between NumRequesters local requesters with
// round-robin arbitration. req_ready/rsp_valid are registered single-cycle
// pulses; a completing ACCESS can accept the next winner in the same cycle.
// Optional ACCESS timeout: define RENODE_APB3_ARB_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | bus idle (psel=0), waiting for any req_valid
// ST_SETUP  | APB3 setup phase (psel=1, penable=0), transfer latched
// ST_ACCESS | APB3 access phase (psel=1, penable=1), waiting for pready
module renode_apb3_arbiter
    import renode_pkg::*;
#(
    parameter int NumRequesters = 2,
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                                  pclk,
    input  logic                                  presetn,
    input  logic [NumRequesters-1:0]              req_valid,
    output logic [NumRequesters-1:0]              req_ready,
    input  logic [NumRequesters*AddressWidth-1:0] req_addr,
    input  logic [NumRequesters-1:0]              req_write,
    input  logic [NumRequesters*DataWidth-1:0]    req_wdata,
    output logic [NumRequesters-1:0]              rsp_valid,
    output logic [DataWidth-1:0]                  rsp_rdata,
    output logic                                  rsp_err,
    output logic [AddressWidth-1:0]               paddr,
    output logic                                  pwrite,
    output logic [DataWidth-1:0]                  pwdata,
    output logic                                  psel,
    output logic                                  penable,
    input  logic                                  pready,
    input  logic [DataWidth-1:0]                  prdata,
    input  logic                                  pslverr
);

    localparam int IdxW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

    if (NumRequesters < 2 || NumRequesters > MaxRequesters || TimeoutCycles < 1 ||
        !(DataWidth == 8 || DataWidth == 16 || DataWidth == 32)) begin : g_bad_cfg
        $error("renode_apb3_arbiter: unsupported parameter set");
    end

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        return (i == IdxW'(NumRequesters-1)) ? '0 : i + 1'b1;
    endfunction

    apb3_arb_state_e           state_q, state_d;
    logic [IdxW-1:0]           owner_q, rr_ptr_q, arb_ptr, win_idx;
    logic [NumRequesters-1:0]  grant;
    logic                      req_any;
    logic                      accept, done, abort;

    // Back-to-back arbitration happens in the completing cycle, so it already
    // uses the pointer the completion is about to store.
    assign arb_ptr = (state_q == ST_ACCESS) ? next_idx(owner_q) : rr_ptr_q;

    renode_rr_arbiter #(
        .NumRequesters (NumRequesters),
        .IdxWidth      (IdxW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (arb_ptr),
        .grant   (grant),
        .idx     (win_idx),
        .req_any (req_any)
    );

`ifdef RENODE_APB3_ARB_TIMEOUT_EN
    localparam int TmoW = $clog2(TimeoutCycles + 1);
    logic [TmoW-1:0] tmo_cnt_q;

    // ACCESS-phase down-counter; loaded during SETUP, terminal count at zero.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            tmo_cnt_q <= TmoW'(TimeoutCycles - 1);
        end else if (state_q == ST_ACCESS && tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (!presetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state and transfer control strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pready) begin
                    done = 1'b1;
                    if (req_any) begin
                        accept  = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef RENODE_APB3_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latched transfer, registered bus outputs, responses and rr pointer.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
        end else begin
            req_ready <= accept ? grant : '0;
            rsp_valid <= (done || abort) ? (NumRequesters'(1) << owner_q) : '0;
            rsp_rdata <= (done && !pwrite) ? prdata : '0;
            rsp_err   <= done ? pslverr : abort;
            psel      <= (state_d != ST_IDLE);
            penable   <= (state_d == ST_ACCESS);
            if (accept) begin
                paddr   <= req_addr[win_idx*AddressWidth +: AddressWidth];
                pwrite  <= req_write[win_idx];
                pwdata  <= req_wdata[win_idx*DataWidth +: DataWidth];
                owner_q <= win_idx;
            end
            if (done || abort) begin
                rr_ptr_q <= next_idx(owner_q);
            end
        end
    end

endmodule

// File: tb/tb_renode_apb3_arbiter.sv
// Scoreboard bench for renode_apb3_arbiter: queued requesters, a reactive
// APB3 completer model, and a monitor checking responses against predictions.
module tb_renode_apb3_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 20;
    localparam int DW   = 32;
    localparam int TO   = 16;

    typedef struct { logic [AW-1:0] addr; logic write; logic [DW-1:0] wdata; } req_t;
    typedef struct { int owner; logic [AW-1:0] addr; logic write; logic [DW-1:0] wdata; int cyc; } acc_t;
    typedef struct { int owner; logic [DW-1:0] rdata; logic err; int cyc; } exp_t;

    logic                 pclk = 1'b0;
    logic                 presetn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ-1:0]      req_write = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic [AW-1:0]        paddr;
    logic                 pwrite;
    logic [DW-1:0]        pwdata;
    logic                 psel, penable;
    logic                 pready = 1'b0;
    logic [DW-1:0]        prdata = '0;
    logic                 pslverr = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_total = 0;
    int rsp_count = 0;
    int ref_ptr = 0;

    req_t pend_q[NREQ][$];
    acc_t acc_q[$];
    exp_t exp_q[$];

    int          cfg_rand = 0;
    int          cfg_waits = 0;
    logic [DW-1:0] cfg_data = '0;
    logic        cfg_err = 1'b0;

    renode_apb3_arbiter #(
        .NumRequesters (NREQ),
        .AddressWidth  (AW),
        .DataWidth     (DW),
        .TimeoutCycles (TO)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .psel      (psel),
        .penable   (penable),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic bit all_pend_empty();
        for (int i = 0; i < NREQ; i++) if (pend_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Requester side: predict each grant from the request vector that was
    // actually presented, then present the next queued request.
    always @(negedge pclk) begin
        int exp_w;
        int c;
        acc_t a;
        if (!presetn) begin
            for (int i = 0; i < NREQ; i++) pend_q[i].delete();
            acc_q.delete();
            ref_ptr   = 0;
            acc_total = rsp_count;
        end else if (req_ready != '0) begin
            exp_w = -1;
            for (int k = 0; k < NREQ; k++) begin
                c = (ref_ptr + k) % NREQ;
                if (exp_w < 0 && req_valid[c]) exp_w = c;
            end
            chk("grant", 64'(req_ready), (exp_w < 0) ? 64'd0 : (64'd1 << exp_w));
            if (exp_w >= 0 && pend_q[exp_w].size() != 0) begin
                a.owner = exp_w;
                a.addr  = pend_q[exp_w][0].addr;
                a.write = pend_q[exp_w][0].write;
                a.wdata = pend_q[exp_w][0].wdata;
                a.cyc   = cyc;
                acc_q.push_back(a);
                void'(pend_q[exp_w].pop_front());
                ref_ptr = (exp_w + 1) % NREQ;
                acc_total++;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (pend_q[i].size() != 0);
            if (pend_q[i].size() != 0) begin
                req_addr[i*AW +: AW]  = pend_q[i][0].addr;
                req_write[i]          = pend_q[i][0].write;
                req_wdata[i*DW +: DW] = pend_q[i][0].wdata;
            end
        end
    end

    // Completer model: inserts wait states, answers, and predicts the response.
    acc_t cur;
    int   acc_cnt = 0, wait_left = 0, wait_total = 0;
    always @(negedge pclk) begin
        exp_t e;
        if (!presetn || !psel) begin
            pready  = 1'b0;
            acc_cnt = 0;
            if (!presetn) exp_q.delete();
        end else if (!penable) begin
            pready     = 1'b0;
            acc_cnt    = 0;
            wait_total = (cfg_rand != 0) ? int'($urandom_range(0, 3)) : cfg_waits;
            wait_left  = wait_total;
        end else begin
            if (acc_cnt == 0) begin
                if (acc_q.size() == 0) begin
                    chk("access_without_accept", 64'(psel), 64'd0);
                    cur = '{-1, '0, 1'b0, '0, 0};
                end else begin
                    cur = acc_q.pop_front();
                end
            end
            acc_cnt++;
            chk("paddr", 64'(paddr), 64'(cur.addr));
            chk("pwrite", 64'(pwrite), 64'(cur.write));
            if (cur.write) chk("pwdata", 64'(pwdata), 64'(cur.wdata));
            if (wait_left == 0) begin
                pready  = 1'b1;
                prdata  = (cfg_rand != 0) ? DW'($urandom) : cfg_data;
                pslverr = (cfg_rand != 0) ? ($urandom_range(0, 3) == 0) : cfg_err;
                e.owner = cur.owner;
                e.rdata = cur.write ? {DW{1'b0}} : prdata;
                e.err   = pslverr;
                e.cyc   = cur.cyc + 2 + wait_total;
                exp_q.push_back(e);
            end else begin
                pready = 1'b0;
                wait_left--;
`ifdef RENODE_APB3_ARB_TIMEOUT_EN
                if (acc_cnt == TO) begin
                    e.owner = cur.owner;
                    e.rdata = '0;
                    e.err   = 1'b1;
                    e.cyc   = cur.cyc + 1 + TO;
                    exp_q.push_back(e);
                end
`endif
            end
        end
    end

    // Response monitor: every rsp_valid pulse must match the oldest prediction.
    always @(negedge pclk) begin
        exp_t e;
        if (presetn && rsp_valid != '0) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_owner", 64'(rsp_valid), 64'd1 << e.owner);
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic push_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        req_t r;
        r.addr = a; r.write = w; r.wdata = d;
        pend_q[i].push_back(r);
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (!(all_pend_empty() && acc_total == rsp_count && psel == 1'b0) && n < budget) begin
            @(negedge pclk);
            n++;
        end
        chk(nm, 64'(n < budget), 64'd1);
    endtask

    task automatic wait_access(input int budget);
        int n = 0;
        while (!(psel && penable) && n < budget) begin
            @(negedge pclk);
            n++;
        end
        chk("wait_access", 64'(n < budget), 64'd1);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge pclk);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        @(posedge pclk); #1 presetn = 1'b1;
        @(negedge pclk);

        // Single read, zero wait states
        cfg_rand = 0; cfg_waits = 0; cfg_data = 32'hDEADBEEF; cfg_err = 1'b0;
        push_req(0, 20'h00100, 1'b0, '0);
        drain("single_read_done", 20);

        // Contention: two requesters, two transfers each, bus never idles
        push_req(0, 20'h00200, 1'b1, 32'h11111111);
        push_req(1, 20'h00300, 1'b0, '0);
        push_req(0, 20'h00204, 1'b0, '0);
        push_req(1, 20'h00304, 1'b1, 32'h22222222);
        n = 0;
        while (!psel && n < 10) begin @(negedge pclk); n++; end
        n = 0;
        while (psel && n < 40) begin @(negedge pclk); n++; end
        chk("b2b_psel_run", 64'(n), 64'd8);
        drain("contention_done", 20);

        // Write with three wait states
        cfg_waits = 3;
        push_req(2, 20'h00004, 1'b1, 32'h000055AA);
        drain("wait_write_done", 30);

        // Error response for one owner, clean response after
        cfg_waits = 1; cfg_err = 1'b1; cfg_data = 32'hCAFEF00D;
        push_req(1, 20'h00020, 1'b0, '0);
        drain("err_done", 20);
        cfg_err = 1'b0; cfg_data = 32'h0BADCAFE;
        push_req(0, 20'h00024, 1'b0, '0);
        drain("post_err_done", 20);

        // Reset during ACCESS: transfer dropped, pointer back to requester 0
        cfg_waits = 8;
        push_req(1, 20'h00040, 1'b0, '0);
        wait_access(20);
        @(posedge pclk); #1 presetn = 1'b0;
        @(posedge pclk); #1 presetn = 1'b1;
        @(negedge pclk);
        chk("mid_rst_psel", 64'(psel), 64'd0);
        chk("mid_rst_penable", 64'(penable), 64'd0);
        repeat (4) @(negedge pclk);
        cfg_waits = 0;
        push_req(2, 20'h00050, 1'b0, '0);
        push_req(0, 20'h00060, 1'b0, '0);
        drain("post_rst_done", 30);

`ifdef RENODE_APB3_ARB_TIMEOUT_EN
        // Completer never answers: abort with error after TO ACCESS cycles
        cfg_waits = 1000;
        push_req(1, 20'h00070, 1'b0, '0);
        drain("timeout_done", 60);
        chk("timeout_psel_idle", 64'(psel), 64'd0);
`endif

        // Randomized traffic
        cfg_rand = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge pclk);
            for (int i = 0; i < NREQ; i++) begin
                if (pend_q[i].size() < 2 && $urandom_range(0, 2) == 0) begin
                    push_req(i, AW'($urandom), 1'($urandom), DW'($urandom));
                end
            end
        end
        drain("random_done", 600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
